// File: rtl/systolic_feeder_pkg.sv
// Shared sizing and FSM state type for the systolic array input feeder.
package systolic_feeder_pkg;

   localparam int N        = 4;
   localparam int NUM_BITS = 8;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      ARMED  = 2'd1,
      STREAM = 2'd2
   } feeder_state_t;

endpackage

// File: rtl/operand_skew.sv
// One N x N operand buffer that emits N diagonally skewed, zero-padded edge lanes.
// TRANSPOSE=0 reads mem[lane][t-lane] (west edge), TRANSPOSE=1 reads mem[t-lane][lane] (north edge).
module operand_skew #(
   parameter int N         = 4,
   parameter int NUM_BITS  = 8,
   parameter bit TRANSPOSE = 1'b0
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         wr_en_i,
   input  logic [((N > 1) ? $clog2(N) : 1)-1:0] wr_row_i,
   input  logic [N-1:0][NUM_BITS-1:0]   row_i,
   input  logic                         en_i,
   input  logic [$clog2(2*N)-1:0]       t_i,
   output logic [N-1:0][NUM_BITS-1:0]   lane_o
);

   localparam int R_W = (N > 1) ? $clog2(N) : 1;
   localparam int T_W = $clog2(2 * N);

   logic [N-1:0][NUM_BITS-1:0] mem_q [N];
   logic [N-1:0][NUM_BITS-1:0] lane_d;
   logic [N-1:0][NUM_BITS-1:0] lane_q;
   logic [R_W-1:0]             k;

   // Operand storage carries no reset: its contents are meaningless until a full load.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_row_i] <= row_i;
      end
   end

   // Lane l sees element k = t - l only while that index lies inside the matrix.
   always_comb begin
      lane_d = '0;
      k      = '0;
      for (int l = 0; l < N; l++) begin
         if (en_i && (t_i >= T_W'(l)) && ((t_i - T_W'(l)) < T_W'(N))) begin
            k         = R_W'(t_i - T_W'(l));
            lane_d[l] = TRANSPOSE ? mem_q[k][l] : mem_q[l][k];
         end else begin
            lane_d[l] = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lane_q <= '0;
      end else begin
         lane_q <= lane_d;
      end
   end

   assign lane_o = lane_q;

endmodule

// File: rtl/systolic_feeder.sv
// Loads A and B one row per beat, then streams them skewed into the array's west/north edges.
module systolic_feeder #(
   parameter int N        = systolic_feeder_pkg::N,
   parameter int NUM_BITS = systolic_feeder_pkg::NUM_BITS
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       wr_valid_i,
   output logic                       wr_ready_o,
   input  logic [N-1:0][NUM_BITS-1:0] a_row_i,
   input  logic [N-1:0][NUM_BITS-1:0] b_row_i,
   output logic                       armed_o,
   input  logic                       start_i,
   output logic                       busy_o,
   output logic [N-1:0][NUM_BITS-1:0] west_o,
   output logic [N-1:0][NUM_BITS-1:0] north_o,
   output logic                       out_valid_o,
   output logic                       done_o
);

   import systolic_feeder_pkg::*;

   localparam int R_W = (N > 1) ? $clog2(N) : 1;
   localparam int T_W = $clog2(2 * N);
   localparam logic [R_W-1:0] ROW_LAST = R_W'(N - 1);
   localparam logic [T_W-1:0] T_LAST   = T_W'(2 * N - 2);

   feeder_state_t  state_q, state_d;
   logic [R_W-1:0] row_cnt_q, row_cnt_d;
   logic [T_W-1:0] t_q, t_d;
   logic           done_q, done_d;
   logic           wr_en;
   logic           lane_en;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= LOAD;
         row_cnt_q <= '0;
         t_q       <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         t_q       <= t_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      t_d       = t_q;
      done_d    = 1'b0;
      wr_en     = 1'b0;
      case (state_q)
         LOAD: begin
            if (wr_valid_i) begin
               wr_en = 1'b1;
               if (row_cnt_q == ROW_LAST) begin
                  row_cnt_d = '0;
                  state_d   = ARMED;
               end else begin
                  row_cnt_d = row_cnt_q + R_W'(1);
               end
            end else begin
               row_cnt_d = row_cnt_q;
            end
         end
         ARMED: begin
            if (start_i) begin
               state_d = STREAM;
               t_d     = '0;
            end else begin
               state_d = ARMED;
            end
         end
         STREAM: begin
            if (t_q == T_LAST) begin
               state_d   = LOAD;
               row_cnt_d = '0;
               t_d       = '0;
               done_d    = 1'b1;
            end else begin
               t_d = t_q + T_W'(1);
            end
         end
         default: begin
            state_d   = LOAD;
            row_cnt_d = '0;
            t_d       = '0;
         end
      endcase
   end

   // Lanes are registered, so they are computed from the stream index of the coming cycle.
   assign lane_en = (state_d == STREAM);

   operand_skew #(
      .N         (N),
      .NUM_BITS  (NUM_BITS),
      .TRANSPOSE (1'b0)
   ) u_skew_a (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .wr_en_i  (wr_en),
      .wr_row_i (row_cnt_q),
      .row_i    (a_row_i),
      .en_i     (lane_en),
      .t_i      (t_d),
      .lane_o   (west_o)
   );

   operand_skew #(
      .N         (N),
      .NUM_BITS  (NUM_BITS),
      .TRANSPOSE (1'b1)
   ) u_skew_b (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .wr_en_i  (wr_en),
      .wr_row_i (row_cnt_q),
      .row_i    (b_row_i),
      .en_i     (lane_en),
      .t_i      (t_d),
      .lane_o   (north_o)
   );

   assign wr_ready_o  = (state_q == LOAD);
   assign armed_o     = (state_q == ARMED);
   assign busy_o      = (state_q == STREAM);
   assign out_valid_o = (state_q == STREAM);
   assign done_o      = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: each stream's expected edge traffic is queued at start_i.
module tb_systolic_feeder;

   localparam int N = 4;
   localparam int W = 8;

   logic                clk = 1'b0;
   logic                rst_ni = 1'b0;
   logic                wr_valid_i = 1'b0;
   logic                start_i = 1'b0;
   logic [N-1:0][W-1:0] a_row_i = '0;
   logic [N-1:0][W-1:0] b_row_i = '0;
   logic [N-1:0][W-1:0] west_o, north_o;
   logic                wr_ready_o, armed_o, busy_o, out_valid_o, done_o;

   always #5 clk = ~clk;

   systolic_feeder #(.N(N), .NUM_BITS(W)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .wr_valid_i  (wr_valid_i),
      .wr_ready_o  (wr_ready_o),
      .a_row_i     (a_row_i),
      .b_row_i     (b_row_i),
      .armed_o     (armed_o),
      .start_i     (start_i),
      .busy_o      (busy_o),
      .west_o      (west_o),
      .north_o     (north_o),
      .out_valid_o (out_valid_o),
      .done_o      (done_o)
   );

   typedef struct {
      logic [N*W-1:0] west;
      logic [N*W-1:0] north;
      logic           done;
      int             cyc;
   } exp_t;

   exp_t           sb[$];
   exp_t           mon_e;
   int             n_checks = 0;
   int             n_pass = 0;
   int             cyc = 0;
   logic [W-1:0]   ma [N][N];
   logic [W-1:0]   mb [N][N];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
   endfunction

   // Monitor: every valid or done cycle must match the head of the scoreboard; idle lanes must be zero.
   always @(negedge clk) begin
      if (rst_ni) begin
         if (out_valid_o || done_o) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", {62'd0, out_valid_o, done_o}, 64'd0);
            end else begin
               mon_e = sb.pop_front();
               chk("west",  west_o,      mon_e.west);
               chk("north", north_o,     mon_e.north);
               chk("done",  done_o,      mon_e.done);
               chk("valid", out_valid_o, !mon_e.done);
               chk("busy",  busy_o,      !mon_e.done);
               chk("cycle", cyc,         mon_e.cyc);
            end
         end else begin
            chk("idle_lanes", {west_o, north_o}, 64'd0);
         end
      end
   end

   // Reference: west lane i is row i of A delayed by i cycles, north lane j is column j of B delayed by j.
   task automatic push_stream();
      logic [W-1:0] wl [N][2*N-1];
      logic [W-1:0] nl [N][2*N-1];
      exp_t e;
      int   base;
      for (int i = 0; i < N; i++)
         for (int t = 0; t < 2*N-1; t++) begin
            wl[i][t] = '0;
            nl[i][t] = '0;
         end
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            wl[i][i+k] = ma[i][k];
            nl[i][i+k] = mb[k][i];
         end
      base = cyc + 1;
      for (int t = 0; t < 2*N-1; t++) begin
         for (int i = 0; i < N; i++) begin
            e.west[i*W +: W]  = wl[i][t];
            e.north[i*W +: W] = nl[i][t];
         end
         e.done = 1'b0;
         e.cyc  = base + t;
         sb.push_back(e);
      end
      e.west  = '0;
      e.north = '0;
      e.done  = 1'b1;
      e.cyc   = base + 2*N - 1;
      sb.push_back(e);
   endtask

   task automatic fill_fixed();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            ma[i][k] = W'(16*i + k + 1);
            mb[i][k] = W'(8'h80 + 16*i + k);
         end
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            ma[i][k] = W'($urandom);
            mb[i][k] = W'($urandom);
         end
   endtask

   // All tasks start and end right at a falling edge.
   task automatic load_matrix(input int max_gap, input bit early);
      for (int k = 0; k < N; k++) begin
         for (int c = 0; c < N; c++) begin
            a_row_i[c] = ma[k][c];
            b_row_i[c] = mb[k][c];
         end
         wr_valid_i = 1'b1;
         chk("wr_ready_in_load", wr_ready_o, 1'b1);
         @(negedge clk);
         wr_valid_i = 1'b0;
         a_row_i = N*W'($urandom);
         b_row_i = N*W'($urandom);
         chk("armed_after_beat", armed_o, (k == N-1));
         chk("wr_ready_after_beat", wr_ready_o, (k != N-1));
         if (early && k == 1) begin
            start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
            chk("early_start_busy", busy_o, 1'b0);
            chk("early_start_armed", armed_o, 1'b0);
         end
         repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      end
   endtask

   task automatic run_stream(input bit spot, input int abort_t);
      push_stream();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int t = 0; t < 2*N-1; t++) begin
         if (spot && t == 0) begin
            chk("t0_west",  west_o,  32'h0000_0001);
            chk("t0_north", north_o, 32'h0000_0080);
         end
         if (spot && t == 3) begin
            chk("t3_west",  west_o,  32'h3122_1304);
            chk("t3_north", north_o, 32'h8392_A1B0);
         end
         if (spot && t == 6) begin
            chk("t6_west",  west_o,  32'h3400_0000);
            chk("t6_north", north_o, 32'hB300_0000);
         end
         if (t == abort_t) begin
            #2 rst_ni = 1'b0;
            sb.delete();
            #1;
            chk("abort_busy",  busy_o,      1'b0);
            chk("abort_valid", out_valid_o, 1'b0);
            chk("abort_done",  done_o,      1'b0);
            chk("abort_lanes", {west_o, north_o}, 64'd0);
            chk("abort_ready", wr_ready_o,  1'b1);
            @(negedge clk);
            rst_ni = 1'b1;
            @(negedge clk);
            chk("post_abort_ready", wr_ready_o, 1'b1);
            chk("post_abort_armed", armed_o,    1'b0);
            return;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #1;
      chk("rst_ready", wr_ready_o, 1'b1);
      chk("rst_armed", armed_o,    1'b0);
      chk("rst_busy",  busy_o,     1'b0);
      chk("rst_done",  done_o,     1'b0);
      chk("rst_lanes", {west_o, north_o}, 64'd0);
      repeat (3) @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", wr_ready_o, 1'b1);
      chk("post_rst_lanes", {west_o, north_o}, 64'd0);

      fill_fixed();
      load_matrix(2, 1'b1);
      repeat (2) @(negedge clk);
      chk("armed_holds", armed_o, 1'b1);
      a_row_i = N*W'($urandom);
      b_row_i = N*W'($urandom);
      wr_valid_i = 1'b1;
      @(negedge clk);
      wr_valid_i = 1'b0;
      chk("extra_beat_armed", armed_o,    1'b1);
      chk("extra_beat_ready", wr_ready_o, 1'b0);
      run_stream(1'b1, -1);

      fill_random();
      load_matrix(0, 1'b0);
      run_stream(1'b0, -1);

      fill_random();
      load_matrix(1, 1'b0);
      run_stream(1'b0, 2);

      fill_fixed();
      load_matrix(1, 1'b0);
      run_stream(1'b1, -1);

      for (int r = 0; r < 3; r++) begin
         fill_random();
         load_matrix(2, 1'b0);
         repeat ($urandom_range(2, 0)) @(negedge clk);
         run_stream(1'b0, -1);
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Input staging stage directly upstream of the N x N PE array top level.
- Buffers one N x N A operand and one N x N B operand, loaded one row per beat.
- Streams both operands into the array edges with diagonal skew and zero padding: A goes to the west edge, B to the north edge.
- Tells the array controller when operands are armed, and when a stream is running or complete.

Parameters:
- N, default pkg::N: array dimension, which is both the matrix size and the number of edge lanes; minimum 1.
- NUM_BITS, default pkg::NUM_BITS: element width.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- wr_valid_i  input  1  a_row_i/b_row_i hold a valid row beat
- wr_ready_o  output  1  feeder accepts a row beat this cycle
- a_row_i  input  [NUM_BITS-1:0] x N  row k of A; element [c] = A[k][c]
- b_row_i  input  [NUM_BITS-1:0] x N  row k of B; element [c] = B[k][c]
- armed_o  output  1  both matrices fully loaded, waiting for start (drives controller ready_i)
- start_i  input  1  begin streaming; honoured only while armed_o=1
- busy_o  output  1  streaming in progress
- west_o  output  [NUM_BITS-1:0] x N  west edge lanes, one per array row i
- north_o  output  [NUM_BITS-1:0] x N  north edge lanes, one per array column j
- out_valid_o  output  1  west_o/north_o carry a stream cycle
- done_o  output  1  one-cycle pulse after the last stream cycle

Behaviour:
- Reset (rst_ni=0, asynchronous) forces the following:
  - state LOAD, row_cnt=0, t=0;
  - wr_ready_o=1, armed_o=0, busy_o=0, out_valid_o=0, done_o=0;
  - all west_o/north_o lanes = 0.
  - Buffer contents are not cleared; they are don't-care.
- State machine:
  - LOAD:
    - wr_ready_o=1.
    - Each clock edge with wr_valid_i=1 writes a_row_i and b_row_i into buffer row row_cnt, then increments row_cnt.
    - The beat that writes row N-1 moves the FSM to ARMED.
    - start_i is ignored.
  - ARMED:
    - armed_o=1, wr_ready_o=0; wr_valid_i is ignored.
    - start_i=1 at an edge moves the FSM to STREAM with t=0.
  - STREAM:
    - busy_o=1, out_valid_o=1, wr_ready_o=0; start_i and wr_valid_i are ignored.
    - t increments every cycle.
    - The cycle with t=2N-2 is the last; the next edge moves the FSM to LOAD with row_cnt=0, and done_o=1 for exactly that following cycle.
- Skew rule, all outputs registered:
  - During stream cycle t, west_o[i] = A[i][t-i] when 0 <= t-i <= N-1, else 0.
  - During stream cycle t, north_o[j] = B[t-j][j] when 0 <= t-j <= N-1, else 0.
- Outside STREAM, all lanes = 0 (the PEs accumulate, so padding must be exact zero).
- Latency:
  - start_i is sampled at edge e; stream cycle t=0 appears in the cycle after e.
  - A full run is 2N-1 valid cycles followed by 1 done cycle.
- Boundaries:
  - N=1: a single stream cycle with west_o[0]=A[0][0] and north_o[0]=B[0][0].
  - Gaps in wr_valid_i are allowed; row_cnt holds across them.
  - In LOAD the next row load may begin in the same cycle done_o is high.
  - Reset asserted mid-LOAD or mid-STREAM aborts the operation immediately.
    - done_o is not pulsed.
    - Outputs take their reset values.
    - A new full N-row load is required.

Decomposition:
- pkg gains feeder_state_t (LOAD, ARMED, STREAM) and reuses the existing N and NUM_BITS.
- One natural sub-module, operand_skew:
  - holds one N x N buffer and produces N skewed, zero-padded lanes from the shared t;
  - instantiated twice: A indexed [lane][t-lane], B indexed [t-lane][lane];
  - the FSM, counters and handshake live in systolic_feeder.

Test Plan (N=4, NUM_BITS=8; A[i][k]=16*i+k+1, B[k][j]=0x80+16*k+j):
- Reset:
  - Assert rst_ni=0 asynchronously mid-cycle -> all outputs reach their reset values immediately.
  - After release: wr_ready_o=1, armed_o=0, every lane 0x00.
- Load with gaps:
  - 4 row beats separated by idle cycles -> armed_o=1 only after the 4th accepted beat, and wr_ready_o=0 from then on.
  - A 5th wr_valid_i while armed_o=1 -> ignored; the streamed data is unchanged.
- Stream:
  - start_i -> next cycle is t=0: west_o={0x01,0,0,0}, north_o={0x80,0,0,0}.
  - t=3: west_o={0x04,0x13,0x22,0x31}, north_o={0xB0,0xA1,0x92,0x83}.
  - t=6: west_o={0,0,0,0x34}, north_o={0,0,0,0xB3}.
  - Following cycle: done_o=1, out_valid_o=0, lanes 0.
- Early start:
  - start_i pulsed after only 2 row beats -> ignored, busy_o stays 0.
  - Loading continues normally afterwards.
- Reset mid-stream:
  - rst_ni=0 at t=2 -> lanes 0 and busy_o=0 at once; done_o never pulses.
  - After release: wr_ready_o=1, and a full reload plus start reproduces the t=3 values above.
- Back-to-back:
  - Reload during the done_o cycle and start again -> the second stream is identical and begins exactly 1 cycle after its start_i.
